fp_addsub_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined IEEE-754 add/subtract unit with valid/ready flow control.

---
 rtl/fp_addsub_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754 add/subtract with flush-to-zero, RNE rounding and exception flags.
// The whole pipe stalls when the result register is full and not being drained.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic                 out_ovf,
  output logic                 out_unf,
  output logic                 out_inv
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned SW  = MAN_W + 4;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned LZW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0]      EXP_ONES = '1;
  localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0]  EXP_MAX  = $signed({2'b00, EXP_ONES});
  localparam logic signed [EW-1:0]  EXP_MIN  = '0;

  function automatic logic [LZW-1:0] f_lzc(input logic [SW-1:0] v);
    f_lzc = LZW'(SW);
    for (int i = 0; i < int'(SW); i++) begin
      if (v[i]) f_lzc = LZW'(int'(SW) - 1 - i);
    end
  endfunction

  assign in_ready = out_ready | ~out_valid;

  // S1: unpack, classify, magnitude swap and alignment
  logic               w_sa, w_sb, w_swap;
  logic [EXP_W-1:0]   w_ea, w_eb, w_big_e, w_sml_e, w_exp_diff;
  logic [MAN_W-1:0]   w_ma, w_mb, w_big_m, w_sml_m;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [2*SW-1:0]    w_sml_wide;
  logic [SW-1:0]      w_sml_sig;
  logic               w1_spec, w1_inv;
  logic [W-1:0]       w1_res;

  assign w_sa     = in_a[W-1];
  assign w_sb     = in_b[W-1] ^ in_op;
  assign w_ea     = in_a[W-2:MAN_W];
  assign w_eb     = in_b[W-2:MAN_W];
  assign w_ma     = in_a[MAN_W-1:0];
  assign w_mb     = in_b[MAN_W-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EXP_ONES) && (w_ma == '0);
  assign w_b_inf  = (w_eb == EXP_ONES) && (w_mb == '0);
  assign w_a_nan  = (w_ea == EXP_ONES) && (w_ma != '0);
  assign w_b_nan  = (w_eb == EXP_ONES) && (w_mb != '0);
  assign w_swap   = (in_b[W-2:0] > in_a[W-2:0]);
  assign w_big_e  = w_swap ? w_eb : w_ea;
  assign w_sml_e  = w_swap ? w_ea : w_eb;
  assign w_big_m  = w_swap ? w_mb : w_ma;
  assign w_sml_m  = w_swap ? w_ma : w_mb;
  assign w_exp_diff = w_big_e - w_sml_e;
  assign w_sml_wide = {1'b1, w_sml_m, 3'b000, SW'(0)} >> w_exp_diff;
  // everything shifted past the sticky position collapses into it
  assign w_sml_sig  = {w_sml_wide[2*SW-1:SW+1], w_sml_wide[SW] | (|w_sml_wide[SW-1:0])};

  always_comb begin
    w1_spec = 1'b1;
    w1_inv  = 1'b0;
    w1_res  = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      w1_res = QNAN;
      w1_inv = 1'b1;
    end else if (w_a_inf) begin
      w1_res = {w_sa, EXP_ONES, MAN_W'(0)};
    end else if (w_b_inf) begin
      w1_res = {w_sb, EXP_ONES, MAN_W'(0)};
    end else if (w_a_zero && w_b_zero) begin
      w1_res = {w_sa & w_sb, (W-1)'(0)};
    end else if (w_a_zero) begin
      w1_res = {w_sb, in_b[W-2:0]};
    end else if (w_b_zero) begin
      w1_res = in_a;
    end else begin
      w1_spec = 1'b0;
    end
  end

  logic               r1_v, r1_spec, r1_inv, r1_sign, r1_sub;
  logic [W-1:0]       r1_res;
  logic [EXP_W-1:0]   r1_exp;
  logic [SW-1:0]      r1_ma, r1_mb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v <= 1'b0; r1_spec <= 1'b0; r1_inv <= 1'b0; r1_sign <= 1'b0; r1_sub <= 1'b0;
      r1_res <= '0; r1_exp <= '0; r1_ma <= '0; r1_mb <= '0;
    end else if (in_ready) begin
      r1_v    <= in_valid;
      r1_spec <= w1_spec;
      r1_inv  <= w1_inv;
      r1_res  <= w1_res;
      r1_sign <= w_swap ? w_sb : w_sa;
      r1_sub  <= w_sa ^ w_sb;
      r1_exp  <= w_big_e;
      r1_ma   <= {1'b1, w_big_m, 3'b000};
      r1_mb   <= w_sml_sig;
    end
  end

  // S2: significand add/subtract and normalisation
  logic [SW:0]             w_sum;
  logic [SW-1:0]           w_dif, w2_m;
  logic [LZW-1:0]          w_lz;
  logic signed [EW-1:0]    w_exp1, w2_exp;
  logic                    w2_spec;
  logic [W-1:0]            w2_res;

  assign w_sum  = {1'b0, r1_ma} + {1'b0, r1_mb};
  assign w_dif  = r1_ma - r1_mb;
  assign w_lz   = f_lzc(w_dif);
  assign w_exp1 = $signed({2'b00, r1_exp});

  always_comb begin
    w2_spec = r1_spec;
    w2_res  = r1_res;
    w2_m    = w_sum[SW-1:0];
    w2_exp  = w_exp1;
    if (r1_sub) begin
      w2_m   = w_dif << w_lz;
      w2_exp = w_exp1 - $signed(EW'(w_lz));
      if (w_dif == '0) begin
        w2_spec = 1'b1;
        w2_res  = r1_spec ? r1_res : '0;
      end
    end else if (w_sum[SW]) begin
      w2_m   = {w_sum[SW:2], w_sum[1] | w_sum[0]};
      w2_exp = w_exp1 + $signed(EW'(1));
    end
  end

  logic                    r2_v, r2_spec, r2_inv, r2_sign;
  logic [W-1:0]            r2_res;
  logic [SW-1:0]           r2_m;
  logic signed [EW-1:0]    r2_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v <= 1'b0; r2_spec <= 1'b0; r2_inv <= 1'b0; r2_sign <= 1'b0;
      r2_res <= '0; r2_m <= '0; r2_exp <= '0;
    end else if (in_ready) begin
      r2_v    <= r1_v;
      r2_spec <= w2_spec;
      r2_inv  <= r1_inv;
      r2_sign <= r1_sign;
      r2_res  <= w2_res;
      r2_m    <= w2_m;
      r2_exp  <= w2_exp;
    end
  end

  // S3: round to nearest even, range check, special bypass
  logic                    w_up;
  logic [MAN_W+1:0]        w_rnd;
  logic [MAN_W-1:0]        w_man3;
  logic signed [EW-1:0]    w_exp3;
  logic [W-1:0]            w3_res;
  logic                    w3_ovf, w3_unf, w3_inv;

  assign w_up   = r2_m[2] & (r2_m[1] | r2_m[0] | r2_m[3]);
  assign w_rnd  = {1'b0, r2_m[SW-1:3]} + (MAN_W+2)'(w_up);
  assign w_exp3 = r2_exp + $signed(EW'(w_rnd[MAN_W+1]));
  assign w_man3 = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];

  always_comb begin
    w3_res = {r2_sign, w_exp3[EXP_W-1:0], w_man3};
    w3_ovf = 1'b0;
    w3_unf = 1'b0;
    w3_inv = 1'b0;
    if (r2_spec) begin
      w3_res = r2_res;
      w3_inv = r2_inv;
    end else if (w_exp3 >= EXP_MAX) begin
      w3_res = {r2_sign, EXP_ONES, MAN_W'(0)};
      w3_ovf = 1'b1;
    end else if (w_exp3 <= EXP_MIN) begin
      w3_res = {r2_sign, (W-1)'(0)};
      w3_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; out_result <= '0;
      out_ovf <= 1'b0; out_unf <= 1'b0; out_inv <= 1'b0;
    end else if (in_ready) begin
      out_valid <= r2_v;
      if (r2_v) begin
        out_result <= w3_res;
        out_ovf    <= w3_ovf;
        out_unf    <= w3_unf;
        out_inv    <= w3_inv;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed IEEE cases plus randomized streams checked
// against a double-precision arithmetic reference with explicit RNE to single.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_ovf, out_unf, out_inv;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf), .out_inv(out_inv)
  );

  // exact widening of a normal single to double
  function automatic real f2d(input logic [31:0] x);
    logic [10:0] e;
    e = 11'({3'b000, x[30:23]}) + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  // round a double to single (RNE), flagging out-of-range exponents; returns {ovf,unf,inv,bits}
  function automatic logic [34:0] d2f(input real s);
    logic [63:0] d;
    logic [24:0] k;
    logic        up;
    int          fe;
    d  = $realtobits(s);
    fe = int'(d[62:52]) - 896;
    k  = {2'b01, d[51:29]};
    up = d[28] & ((|d[27:0]) | d[29]);
    k  = k + 25'(up);
    if (k[24]) fe++;
    if (fe >= 255) return {3'b100, d[63], 8'hFF, 23'd0};
    if (fe <= 0)   return {3'b010, d[63], 31'd0};
    return {3'b000, d[63], fe[7:0], (k[24] ? k[23:1] : k[22:0])};
  endfunction

  function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic sa, sb, az, bz, ai, bi, an, bn;
    real  s;
    sa = a[31];
    sb = b[31] ^ op;
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (an || bn || (ai && bi && (sa != sb))) return {3'b001, 32'h7FC00000};
    if (ai) return {3'b000, sa, 8'hFF, 23'd0};
    if (bi) return {3'b000, sb, 8'hFF, 23'd0};
    if (az && bz) return {3'b000, sa & sb, 31'd0};
    if (az) return {3'b000, sb, b[30:0]};
    if (bz) return {3'b000, a};
    s = f2d(a) + f2d({sb, b[30:0]});
    if (s == 0.0) return 35'd0;
    return d2f(s);
  endfunction

  task automatic gen(output logic [31:0] a, output logic [31:0] b, output logic op);
    int sel;
    a   = $urandom;
    b   = $urandom;
    op  = 1'($urandom_range(0, 1));
    sel = int'($urandom_range(0, 4));
    case (sel)
      1, 2: b[30:23] = a[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
      3:    b[30:0]  = a[30:0];
      4:    b[30:23] = a[30:23] - 8'($urandom_range(23, 25));
      default: ;
    endcase
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({out_valid, out_result, out_ovf, out_unf, out_inv} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_during got=%h exp=0", {out_valid, out_result, out_ovf, out_unf, out_inv});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_total++;
    if ({out_valid, out_result, out_ovf, out_unf, out_inv, in_ready} !== 37'd1) begin
      n_bad++;
      $display("FAIL reset_after got=%h exp=1", {out_valid, out_result, out_ovf, out_unf, out_inv, in_ready});
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_total++;
      if (out_valid !== (c == 3)) begin
        n_bad++;
        $display("FAIL latency_valid cycle=%0d got=%b exp=%b", c, out_valid, (c == 3));
      end
    end
    n_total++;
    if ({out_ovf, out_unf, out_inv, out_result} !== {3'b000, 32'h40400000}) begin
      n_bad++;
      $display("FAIL latency_result got=%h exp=%h", {out_ovf, out_unf, out_inv, out_result}, {3'b000, 32'h40400000});
    end
  endtask

  localparam int ND = 15;
  localparam logic [31:0] D_A [ND] = '{32'h3F800000, 32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h3F800001,
                                       32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h00400000, 32'h3F800000,
                                       32'h80000000, 32'h80000000, 32'hFF800000, 32'h00800000, 32'h3F800000};
  localparam logic [31:0] D_B [ND] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h33800000, 32'h33800000,
                                       32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'h40000000,
                                       32'h80000000, 32'h00000000, 32'h3F800000, 32'h00800001, 32'h00400000};
  localparam logic        D_O [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                       1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [34:0] D_E [ND] = '{{3'b000, 32'h40400000}, {3'b000, 32'h00000000}, {3'b000, 32'h00000000},
                                       {3'b000, 32'h3F800000}, {3'b000, 32'h3F800002}, {3'b100, 32'h7F800000},
                                       {3'b001, 32'h7FC00000}, {3'b001, 32'h7FC00000}, {3'b000, 32'h00000000},
                                       {3'b000, 32'hBF800000}, {3'b000, 32'h80000000}, {3'b000, 32'h80000000},
                                       {3'b000, 32'hFF800000}, {3'b010, 32'h80000000}, {3'b000, 32'h3F800000}};

  task automatic test_directed();
    int c;
    out_ready = 1'b1;
    for (int i = 0; i < ND; i++) begin
      @(negedge clk);
      in_a = D_A[i]; in_b = D_B[i]; in_op = D_O[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      c = 0;
      #1;
      while (!out_valid && c < 10) begin
        @(negedge clk); #1;
        c++;
      end
      n_total++;
      if (!out_valid) begin
        n_bad++;
        $display("FAIL directed_timeout idx=%0d got=no_output exp=output", i);
      end else if ({out_ovf, out_unf, out_inv, out_result} !== D_E[i]) begin
        n_bad++;
        $display("FAIL directed idx=%0d got=%h exp=%h", i, {out_ovf, out_unf, out_inv, out_result}, D_E[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream(input int n_ops, input bit rand_bp);
    logic [34:0] q[$];
    logic [34:0] obs, expv, hold_val;
    logic [31:0] a, b;
    logic        op;
    bit          hold_v, pend;
    int          sent, got, cyc;
    hold_v = 1'b0; pend = 1'b0; sent = 0; got = 0; cyc = 0; hold_val = '0;
    in_valid = 1'b0;
    while (got < n_ops && cyc < 40 * n_ops + 100) begin
      @(negedge clk);
      if (!pend) begin
        if (sent < n_ops && (!rand_bp || $urandom_range(0, 3) != 0)) begin
          gen(a, b, op);
          in_a = a; in_b = b; in_op = op; in_valid = 1'b1; pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : !(cyc >= 4 && cyc <= 8);
      #1;
      obs = {out_ovf, out_unf, out_inv, out_result};
      if (hold_v) begin
        n_total++;
        if (!out_valid || obs !== hold_val) begin
          n_bad++;
          $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, obs, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra cyc=%0d got=%h exp=none", cyc, obs);
        end else begin
          expv = q.pop_front();
          if (obs !== expv) begin
            n_bad++;
            $display("FAIL stream_result n=%0d got=%h exp=%h", got, obs, expv);
          end
          got++;
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = obs;
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_a, in_b, in_op));
        sent++;
        pend = 1'b0;
      end
      cyc++;
    end
    n_total++;
    if (got != n_ops || q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count got=%0d exp=%0d pending=%0d", got, n_ops, q.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_total++;
      if (out_valid) begin
        n_bad++;
        $display("FAIL stream_drain cyc=%0d got=1 exp=0", i);
      end
    end
  endtask

  task automatic test_reset_flight();
    logic [31:0] a, b;
    logic        op;
    logic [34:0] expv;
    int          c;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      gen(a, b, op);
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL flight_pre got=%b exp=1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, out_result, out_ovf, out_unf, out_inv} !== 36'd0) begin
      n_bad++;
      $display("FAIL flight_reset got=%h exp=0", {out_valid, out_result, out_ovf, out_unf, out_inv});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      n_total++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flight_ghost cyc=%0d got=%b exp=0", i, out_valid);
      end
    end
    @(negedge clk);
    in_a = 32'h40400000; in_b = 32'h3F800000; in_op = 1'b1; in_valid = 1'b1;
    expv = ref_model(in_a, in_b, in_op);
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    #1;
    while (!out_valid && c < 10) begin
      @(negedge clk); #1;
      c++;
    end
    n_total++;
    if (!out_valid || {out_ovf, out_unf, out_inv, out_result} !== expv) begin
      n_bad++;
      $display("FAIL flight_after got=%b/%h exp=1/%h", out_valid, {out_ovf, out_unf, out_inv, out_result}, expv);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_stream(10, 1'b0);
    test_stream(300, 1'b1);
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
